seq_decoder_n: RTL and testbench
================================

// Module: seq_decoder_n
// PURPOSE
//  Registered, parametrised N-to-2^N one-hot decoder. It is the successor to the
//  fixed 2-to-4 combinational decoder block.
//  DECODE mode: latches a binary select on a load strobe.
//  SCAN mode: steps the active output automatically under a prescaler, for
//  multiplexed display digits, row strobes, etc. Sits between control logic and
//  the board outputs.
// PARAMETERS
//  SEL_W      2            select width; output width is 2**SEL_W (SEL_W >= 1)
//  DIV        4            clocks per scan step in SCAN mode (DIV >= 1)
//  SCAN_LAST  2**SEL_W-1   highest index visited in SCAN mode (0..2**SEL_W-1)
//  ACTIVE_LOW 0            1: active output is 0, inactive outputs are 1
// PORTS
//  clk     in   1          single clock, rising edge
//  rst_n   in   1          asynchronous active-low reset
//  en      in   1          1: drive decoded output; 0: blank all outputs, freeze state
//  mode    in   1          0 = DECODE, 1 = SCAN
//  load    in   1          1-cycle strobe: capture sel into index
//  sel     in   SEL_W      binary select, sampled only when load=1
//  vystup  out  2**SEL_W   one-hot (or one-cold) decoded output, registered
//  idx     out  SEL_W      current index register
//  wrap    out  1          1-cycle pulse when SCAN wraps SCAN_LAST -> 0
// BEHAVIOUR
//  Clock and reset:
//  - One clock: clk. Reset rst_n is asynchronous and active-low.
//  - Reset values: idx=0, prescaler cnt=0, wrap=0, vystup all inactive
//    (0s, or all 1s when ACTIVE_LOW=1).
//  - After reset release, vystup stays inactive until the first edge with en=1.
//  Registers:
//  - idx (SEL_W bits)
//  - cnt (clog2(DIV) bits; absent when DIV=1)
//  - vystup, wrap
//  - All outputs are registered. vystup is computed from the NEXT value of idx,
//    so it is coherent with idx on the same cycle.
//  Priority at each edge:
//  1. en=0: vystup <= inactive; idx and cnt hold; wrap <= 0. load is ignored.
//  2. load=1: idx <= sel; cnt <= 0; wrap <= 0. Valid in either mode. It overrides
//     a scan step on the same edge.
//  3. mode=0 (DECODE): idx holds; cnt <= 0; wrap <= 0.
//  4. mode=1 (SCAN), cnt < DIV-1: cnt <= cnt+1; idx holds; wrap <= 0.
//  5. mode=1 (SCAN), cnt == DIV-1: cnt <= 0; the next idx is set as follows:
//     - idx >= SCAN_LAST: idx <= 0 and wrap <= 1.
//     - otherwise: idx <= idx+1 and wrap <= 0.
//  Output:
//  - When en=1: vystup <= (1 << idx_next), inverted when ACTIVE_LOW=1.
//  - Exactly one bit is active whenever en=1.
//  Latency:
//  - load -> vystup: 1 clock.
//  - en 1->0 -> blank: 1 clock. en 0->1 -> drive: 1 clock.
//  - SCAN step period: DIV clocks; full scan period: DIV*(SCAN_LAST+1) clocks.
//  Boundary conditions:
//  - sel > SCAN_LAST in DECODE: decoded normally. In SCAN, the next step wraps
//    to 0 and pulses wrap.
//  - DIV=1: idx advances every enabled SCAN clock.
//  - SCAN_LAST=0: idx stays 0 and wrap pulses every DIV clocks.
//  - mode 1->0: cnt clears; idx keeps its last scanned value.
//  - mode 0->1: the first step occurs DIV clocks later.
//  - Index arithmetic is modulo 2**SEL_W. idx+1 never overflows past SCAN_LAST.
//  - Reset mid-scan: the state clears immediately, with no wait for the clock.
// TESTING
//  1. Reset (SEL_W=2): assert rst_n=0 mid-cycle -> vystup=0000 and idx=0 at once;
//     release rst_n with en=0 -> vystup stays 0000.
//  2. DECODE: en=1, mode=0, load with sel=0,1,2,3 -> next cycle vystup=0001, 0010,
//     0100, 1000; idx matches; wrap stays 0.
//  3. SCAN (DIV=4): en=1, mode=1 from idx=0 -> vystup changes every 4 clocks
//     0001->0010->0100->1000->0001; wrap=1 for exactly the cycle showing 0001.
//  4. SCAN_LAST=2, sel=3 loaded then SCAN -> after 4 clocks idx=0 and wrap=1;
//     idx then cycles 0,1,2.
//  5. en and load: en=0 mid-scan -> vystup=0000 next clock, idx/cnt frozen;
//     en=1 -> scan resumes from the same idx/cnt. Load sel=1 with cnt=3 ->
//     idx=1 (no step) and cnt=0.
//  6. Config SEL_W=3, ACTIVE_LOW=1: load sel=5 -> vystup=8'b1101_1111; en=0 -> 8'hFF.

Source files
------------

// File: rtl/seq_decoder_n.sv
// Registered N-to-2^N one-hot decoder with DECODE mode (latched select) and
// SCAN mode (auto-stepping active output under a prescaler).
module seq_decoder_n #(
    parameter int SEL_W      = 2,
    parameter int DIV        = 4,
    parameter int SCAN_LAST  = 2**SEL_W - 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   sel,
    output logic [2**SEL_W-1:0] vystup,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap
);
    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(SCAN_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    // With DIV=1 the prescaler is pinned at 0 == CNT_MAX, so every SCAN clock steps.
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [SEL_W-1:0] idx_next;
    logic             wrap_next;
    logic [OUT_W-1:0] vystup_next;

    always_comb begin
        idx_next    = idx;
        cnt_next    = cnt;
        wrap_next   = 1'b0;
        vystup_next = INACTIVE;
        if (en) begin
            if (load) begin
                idx_next = sel;
                cnt_next = '0;
            end else if (!mode) begin
                cnt_next = '0;
            end else if (cnt != CNT_MAX) begin
                cnt_next = cnt + CNT_W'(1);
            end else begin
                cnt_next = '0;
                if (idx >= LAST) begin
                    idx_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    idx_next = idx + SEL_W'(1);
                end
            end
            // Decode the next index so vystup and idx stay coherent each cycle.
            vystup_next = (OUT_W'(1) << idx_next) ^ INACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            cnt    <= '0;
            wrap   <= 1'b0;
            vystup <= INACTIVE;
        end else begin
            idx    <= idx_next;
            cnt    <= cnt_next;
            wrap   <= wrap_next;
            vystup <= vystup_next;
        end
    end

endmodule

// File: tb/tb_seq_decoder_n.sv
// Randomised and directed bench for seq_decoder_n across four configurations,
// scored against a cycle-level reference model of the decode/scan rules.
module tb_seq_decoder_n;
    logic clk, rst_n, en, mode, load;
    logic [1:0] sel2;
    logic [2:0] sel3;

    logic [3:0] vy_a, vy_b, vy_d;
    logic [7:0] vy_c;
    logic [1:0] idx_a, idx_b, idx_d;
    logic [2:0] idx_c;
    logic wrap_a, wrap_b, wrap_c, wrap_d;

    seq_decoder_n u_a (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
                       .sel(sel2), .vystup(vy_a), .idx(idx_a), .wrap(wrap_a));
    seq_decoder_n #(.SCAN_LAST(2)) u_b (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
                       .load(load), .sel(sel2), .vystup(vy_b), .idx(idx_b), .wrap(wrap_b));
    seq_decoder_n #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1)) u_c (.clk(clk), .rst_n(rst_n),
                       .en(en), .mode(mode), .load(load), .sel(sel3), .vystup(vy_c),
                       .idx(idx_c), .wrap(wrap_c));
    seq_decoder_n #(.SCAN_LAST(0), .DIV(3)) u_d (.clk(clk), .rst_n(rst_n), .en(en),
                       .mode(mode), .load(load), .sel(sel2), .vystup(vy_d), .idx(idx_d),
                       .wrap(wrap_d));

    logic [7:0] vy_obs [4];
    logic [2:0] idx_obs [4];
    logic       wrap_obs [4];
    assign vy_obs[0] = {4'b0, vy_a};
    assign vy_obs[1] = {4'b0, vy_b};
    assign vy_obs[2] = vy_c;
    assign vy_obs[3] = {4'b0, vy_d};
    assign idx_obs[0] = {1'b0, idx_a};
    assign idx_obs[1] = {1'b0, idx_b};
    assign idx_obs[2] = idx_c;
    assign idx_obs[3] = {1'b0, idx_d};
    assign wrap_obs[0] = wrap_a;
    assign wrap_obs[1] = wrap_b;
    assign wrap_obs[2] = wrap_c;
    assign wrap_obs[3] = wrap_d;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model configuration and state
    int cfg_w    [4] = '{2, 2, 3, 2};
    int cfg_div  [4] = '{4, 4, 1, 3};
    int cfg_last [4] = '{3, 2, 7, 0};
    int cfg_al   [4] = '{0, 0, 1, 0};
    int m_idx [4];
    int m_cnt [4];
    int m_wrap[4];
    int m_vy  [4];

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int inactive(int k);
        return (cfg_al[k] != 0) ? ((1 << (1 << cfg_w[k])) - 1) : 0;
    endfunction

    task automatic push_expected();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'(m_vy[k]));
            exp_q.push_back(32'(m_idx[k]));
            exp_q.push_back(32'(m_wrap[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_vy[k] = inactive(k);
        end
        push_expected();
    endtask

    task automatic model_step();
        int n, s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 4; k++) begin
            n = 1 << cfg_w[k];
            s = (k == 2) ? int'(sel3) : int'(sel2);
            m_wrap[k] = 0;
            if (!en) begin
                m_vy[k] = inactive(k);
            end else begin
                if (load) begin
                    m_idx[k] = s % n;
                    m_cnt[k] = 0;
                end else if (!mode) begin
                    m_cnt[k] = 0;
                end else if (m_cnt[k] < cfg_div[k] - 1) begin
                    m_cnt[k]++;
                end else begin
                    m_cnt[k] = 0;
                    if (m_idx[k] >= cfg_last[k]) begin
                        m_idx[k] = 0;
                        m_wrap[k] = 1;
                    end else begin
                        m_idx[k] = (m_idx[k] + 1) % n;
                    end
                end
                m_vy[k] = (1 << m_idx[k]) ^ inactive(k);
            end
        end
        push_expected();
    endtask

    // scoreboard: pops one expected triple per instance
    task automatic compare_all();
        logic [31:0] e;
        for (int k = 0; k < 4; k++) begin
            for (int f = 0; f < 3; f++) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("queue_empty%0d", k), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    case (f)
                        0: check($sformatf("vystup%0d", k), 32'(vy_obs[k]), e);
                        1: check($sformatf("idx%0d", k), 32'(idx_obs[k]), e);
                        default: check($sformatf("wrap%0d", k), 32'(wrap_obs[k]), e);
                    endcase
                end
            end
        end
    endtask

    // driver tasks
    task automatic drive(input logic e, input logic m, input logic l,
                         input logic [1:0] s2, input logic [2:0] s3);
        en = e; mode = m; load = l; sel2 = s2; sel3 = s3;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

        // reset asserted between clock edges, released with en=0
        #12;
        async_reset();
        check("rst_vy_a", 32'(vy_a), 32'h0);
        check("rst_vy_c", 32'(vy_c), 32'hFF);
        cycle();
        #1 rst_n = 1'b1;
        cycle();
        cycle();
        check("idle_vy_a", 32'(vy_a), 32'h0);

        // DECODE loads
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 1'b0, 1'b1, 2'(s), 3'(s + 4));
            cycle();
            check("dec_vy_a", 32'(vy_a), 32'(1 << s));
            drive(1'b1, 1'b0, 1'b0, 2'(s), 3'(s + 4));
            cycle();
        end

        // SCAN from index 0
        drive(1'b1, 1'b1, 1'b1, 2'd0, 3'd0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        repeat (20) cycle();

        // select above SCAN_LAST, then scan
        drive(1'b1, 1'b1, 1'b1, 2'd3, 3'd7);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        repeat (14) cycle();

        // blank mid-scan and resume
        drive(1'b0, 1'b1, 1'b1, 2'd2, 3'd2);
        repeat (3) cycle();
        check("blank_vy_a", 32'(vy_a), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        repeat (6) cycle();

        // load overrides a pending scan step
        drive(1'b1, 1'b1, 1'b1, 2'd0, 3'd0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        repeat (3) cycle();
        drive(1'b1, 1'b1, 1'b1, 2'd1, 3'd5);
        cycle();
        check("load_idx_a", 32'(idx_a), 32'd1);
        check("load_vy_c", 32'(vy_c), 32'hDF);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        cycle();
        check("blank_vy_c", 32'(vy_c), 32'hFF);

        // randomised traffic
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) != 0,
                  ($urandom_range(0, 19) == 0) ? ~mode : mode,
                  $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            cycle();
            if (i == 400) begin
                async_reset();
                #1 rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
